// File: rtl/barrett_mulred_pipe_if.sv
// Operand/result handshake bundle for the Barrett multiply-reduce pipeline.
// The slave side is the reducer; the master side is whoever feeds and drains it.
interface barrett_mulred_pipe_if #(
   parameter int QW   = 12,
   parameter int TAGW = 4
);
   logic            in_valid_i;
   logic            in_ready_o;
   logic [QW-1:0]   a_i;
   logic [QW-1:0]   b_i;
   logic [TAGW-1:0] tag_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [QW-1:0]   res_o;
   logic [TAGW-1:0] tag_o;
   logic            err_o;

   // Valid/ready: a beat moves on a rising edge where valid and ready are both 1.
   // Valid, once raised, holds with its data until it is taken.
   modport slave (
      input  in_valid_i, a_i, b_i, tag_i, out_ready_i,
      output in_ready_o, out_valid_o, res_o, tag_o, err_o
   );

   modport master (
      output in_valid_i, a_i, b_i, tag_i, out_ready_i,
      input  in_ready_o, out_valid_o, res_o, tag_o, err_o
   );
endinterface

// File: rtl/barrett_mulred_pipe.sv
// Three-stage (a*b) mod Q with Barrett reduction: multiply, quotient estimate, correct.
// All stages advance together whenever the output register is free or being drained.
module barrett_mulred_pipe #(
   parameter int Q    = 3329,
   parameter int QW   = 12,
   parameter int TAGW = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic flush_i,
   barrett_mulred_pipe_if.slave bus
);
   localparam int PW = 2 * QW;
   localparam int K  = 2 * QW;
   localparam longint unsigned M_L = (64'd1 << K) / Q;
   localparam int MW = $clog2(M_L + 1);
   localparam logic [MW-1:0]    M   = MW'(M_L);
   localparam logic [QW-1:0]    Q_A = QW'(Q);
   localparam logic [QW+1:0]    Q_N = (QW + 2)'(Q);

   logic adv;

   logic            v1_q, v1_d;
   logic [PW-1:0]   p1_q, p1_d;
   logic            err1_q, err1_d;
   logic [TAGW-1:0] tag1_q, tag1_d;

   logic            v2_q, v2_d;
   logic [PW-1:0]   p2_q, p2_d;
   logic [QW:0]     t2_q, t2_d;
   logic            err2_q, err2_d;
   logic [TAGW-1:0] tag2_q, tag2_d;

   logic            out_valid_q, out_valid_d;
   logic [QW-1:0]   res_q, res_d;
   logic [TAGW-1:0] tag_out_q, tag_out_d;
   logic            err_out_q, err_out_d;

   logic [PW+MW-1:0] pm;
   logic [PW+MW-1:0] pm_sh;
   logic [QW+1:0]    tq;
   logic [QW+1:0]    r0;
   logic [QW+2:0]    d1;
   logic [QW+1:0]    r1;
   logic [QW+2:0]    d2;
   logic [QW+1:0]    r2;

   always_comb begin
      adv = !out_valid_q | bus.out_ready_i;

      v1_d        = v1_q;
      p1_d        = p1_q;
      err1_d      = err1_q;
      tag1_d      = tag1_q;
      v2_d        = v2_q;
      p2_d        = p2_q;
      t2_d        = t2_q;
      err2_d      = err2_q;
      tag2_d      = tag2_q;
      out_valid_d = out_valid_q;
      res_d       = res_q;
      tag_out_d   = tag_out_q;
      err_out_d   = err_out_q;

      pm    = (PW + MW)'(p1_q) * (PW + MW)'(M);
      pm_sh = pm >> K;

      // r0 < 2Q for any p < 2^K, so two conditional subtractions always suffice.
      tq = {1'b0, t2_q} * Q_N;
      r0 = p2_q[QW+1:0] - tq;
      d1 = {1'b0, r0} - {1'b0, Q_N};
      r1 = d1[QW+2] ? r0 : d1[QW+1:0];
      d2 = {1'b0, r1} - {1'b0, Q_N};
      r2 = d2[QW+2] ? r1 : d2[QW+1:0];

      if (adv) begin
         v1_d        = bus.in_valid_i;
         p1_d        = PW'(bus.a_i) * PW'(bus.b_i);
         err1_d      = (bus.a_i >= Q_A) | (bus.b_i >= Q_A);
         tag1_d      = bus.tag_i;
         v2_d        = v1_q;
         p2_d        = p1_q;
         t2_d        = pm_sh[QW:0];
         err2_d      = err1_q;
         tag2_d      = tag1_q;
         out_valid_d = v2_q;
         res_d       = r2[QW-1:0];
         tag_out_d   = tag2_q;
         err_out_d   = err2_q;
      end

      if (flush_i) begin
         v1_d        = 1'b0;
         v2_d        = 1'b0;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v1_q        <= 1'b0;
         p1_q        <= '0;
         err1_q      <= 1'b0;
         tag1_q      <= '0;
         v2_q        <= 1'b0;
         p2_q        <= '0;
         t2_q        <= '0;
         err2_q      <= 1'b0;
         tag2_q      <= '0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         tag_out_q   <= '0;
         err_out_q   <= 1'b0;
      end else begin
         v1_q        <= v1_d;
         p1_q        <= p1_d;
         err1_q      <= err1_d;
         tag1_q      <= tag1_d;
         v2_q        <= v2_d;
         p2_q        <= p2_d;
         t2_q        <= t2_d;
         err2_q      <= err2_d;
         tag2_q      <= tag2_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         tag_out_q   <= tag_out_d;
         err_out_q   <= err_out_d;
      end
   end

   assign bus.in_ready_o  = adv;
   assign bus.out_valid_o = out_valid_q;
   assign bus.res_o       = res_q;
   assign bus.tag_o       = tag_out_q;
   assign bus.err_o       = err_out_q;
endmodule

// File: doc/barrett_mulred_pipe.md
Name: barrett_mulred_pipe

Overview:
- Pipelined, parametrised modular multiplier with Barrett reduction: computes (a_i * b_i) mod Q for NTT/pointwise arithmetic in the lattice core.
- Next generation of the combinational Kyber reducer: the modulus is a parameter, the datapath is registered over 3 stages, and it adds a valid/ready handshake, a flush input, a sideband tag and a range-error flag.
- Sits between the coefficient memory read path and the butterfly/accumulate units.

Parameters:
- Q, 3329, odd modulus, 2 < Q < 2^QW.
- QW, 12, coefficient width in bits.
- TAGW, 4, sideband tag width, passed through unchanged.
- Derived localparams, not overridable: PW = 2*QW (product width), K = 2*QW (Barrett shift), M = floor(2^K / Q) (5039 for defaults).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous pipeline clear.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  block accepts operands this cycle.
- a_i  in  QW  operand a, expected < Q.
- b_i  in  QW  operand b, expected < Q.
- tag_i  in  TAGW  sideband tag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts result.
- res_o  out  QW  (a*b) mod Q, always in [0, Q).
- tag_o  out  TAGW  tag travelling with res_o.
- err_o  out  1  a or b was >= Q for this result.

Behaviour:
- Reset: asynchronous on rst_i high. All stage valids, out_valid_o, res_o, tag_o and err_o go to 0. in_ready_o reads 1 once reset is released.
- Handshake:
  - Input transfer when in_valid_i & in_ready_o.
  - Output transfer when out_valid_o & out_ready_i.
  - adv = !out_valid_o | out_ready_i; in_ready_o = adv (combinational).
  - All three stages shift together when adv = 1 and hold when adv = 0.
  - Bubbles are not compressed.
- Stage 1: p = a*b, PW bits, unsigned. err = (a >= Q) | (b >= Q). Tag and valid registered alongside.
- Stage 2:
  - t = (p * M) >> K. The full product is PW + clog2(M+1) bits wide, truncated to QW+1 bits.
  - p, err, tag and valid forwarded.
- Stage 3:
  - r = p - t*Q, computed in QW+2 bits.
  - Required guarantee: 0 <= r < 3Q.
  - Apply up to two conditional subtractions of Q, each selected by the borrow of (r - Q).
  - Register the result as res_o.
- Latency: 3 cycles from input transfer to out_valid_o when unstalled. Throughput: 1 result per cycle.
- Out-of-range operands: result is still the exact mod-Q value of the p actually formed, provided p < 2^PW. err_o = 1 for that result only.
- Backpressure: while out_valid_o = 1 and out_ready_i = 0, res_o, tag_o and err_o are held stable. No internal stage changes.
- Flush:
  - flush_i = 1 clears every stage valid and out_valid_o at the next edge. It has priority over adv and over an input transfer in the same cycle; that operand pair is dropped.
  - Data registers may keep stale values.
  - in_ready_o is unaffected by flush_i.
- Simultaneous output transfer and new input transfer in the same cycle: both happen and the pipeline shifts. No loss, no duplication.
- Reset mid-operation: all in-flight results are discarded. The first output after reset belongs to the first input accepted after reset.
- Tag ordering: results leave strictly in acceptance order, and each tag_o equals its own tag_i.

Test Plan:
- Reset, then a=1234, b=2345, tag=5, out_ready_i=1 -> 3 cycles later out_valid_o=1, res_o=829, tag_o=5, err_o=0. The output is 1 for exactly one cycle.
- Max operands a=3328, b=3328 -> res_o=1. Also a=0, b=3328 -> res_o=0. Also a=1, b=3328 -> res_o=3328. Checks the double-subtract corner.
- Streaming: 1000 random in-range pairs back-to-back, out_ready_i=1 -> one result per cycle, in order, tags match, each equals golden (a*b)%3329.
- Backpressure: stream with out_ready_i random 50% -> no drop or duplicate. res_o and tag_o stable while stalled. in_ready_o=0 exactly when out_valid_o=1 & out_ready_i=0.
- Error/flush: a=3329, b=1 -> res_o=0, err_o=1. Next pair has err_o=0. flush_i with 2 in flight -> out_valid_o=0 next cycle, and those 2 results never appear.
- Reset mid-stream: assert rst_i asynchronously between edges with 3 in flight -> outputs clear immediately. After release, the first result corresponds to the first post-reset input. Repeat the golden check with Q=7681, QW=13.
